// File: rtl/dm_responder.sv
// dm_responder
// Data-memory responder for the CPU data port. Accepts one load/store at a
// time, performs byte/half/word accesses with little-endian lane merging on
// a word array, and returns the response WAIT_CYCLES+1 cycles after the
// accept edge. Committed stores are reported on a one-cycle trace pulse.
//
// Parameters
//   ADDR_W       byte-address width decoded; DEPTH = 2**(ADDR_W-2) words
//   WAIT_CYCLES  extra cycles between accept and rsp_valid (0..15)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   req_valid    request present            req_ready   high only when idle
//   req_we       1 = store, 0 = load        req_size    00 byte, 01 half, 10 word
//   req_sign     sign-extend byte/half loads
//   req_addr     byte address               req_wdata   right-aligned store data
//   rsp_valid    response held until rsp_ready
//   rsp_rdata    extended load data (0 for stores/errors)
//   rsp_err      misaligned, out of range or reserved size
//   trace_valid  one-cycle pulse after a store commits
//   trace_addr   word-aligned address of the store
//   trace_data   full merged word written
module dm_responder #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        trace_valid,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data
);

   localparam int         DEPTH     = 2 ** (ADDR_W - 2);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        rsp_valid_reg;
   logic        err_reg;
   logic [31:0] rdata_reg;
   logic        trace_valid_reg;
   logic [31:0] taddr_reg;
   logic [31:0] tdata_reg;

   // Memory must be cleared by reset (a reset wipes even committed stores),
   // so it is held in resettable registers rather than a RAM macro.
   logic [31:0] mem [DEPTH];

   logic              accept;
   logic              req_err;
   logic [ADDR_W-3:0] widx;
   logic [31:0]       cur_word;
   logic [31:0]       wrep;
   logic [31:0]       merged_word;
   logic [3:0]        lane_en;
   logic [7:0]        byte_val;
   logic [15:0]       half_val;
   logic [31:0]       load_val;

   assign req_ready = (state_reg == S_IDLE);
   assign accept    = req_valid && (state_reg == S_IDLE);
   assign widx      = req_addr[ADDR_W-1:2];
   assign cur_word  = mem[widx];

   // Anything above the decoded window is an error, never an alias.
   assign req_err = (req_size == 2'b11)
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || (req_size == 2'b01 && req_addr[0])
                 || (|req_addr[31:ADDR_W]);

   always_comb begin
      lane_en = 4'b0000;
      case (req_size)
         2'b00:   lane_en = 4'b0001 << req_addr[1:0];
         2'b01:   lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   // Replicate right-aligned store data onto every lane; lane_en picks.
   always_comb begin
      wrep = req_wdata;
      case (req_size)
         2'b00:   wrep = {4{req_wdata[7:0]}};
         2'b01:   wrep = {2{req_wdata[15:0]}};
         default: wrep = req_wdata;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = lane_en[gi] ? wrep[gi*8 +: 8]
                                                  : cur_word[gi*8 +: 8];
   end

   assign byte_val = cur_word[{req_addr[1:0], 3'b000} +: 8];
   assign half_val = req_addr[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      load_val = '0;
      case (req_size)
         2'b00:   load_val = req_sign ? {{24{byte_val[7]}}, byte_val}
                                      : {24'h0, byte_val};
         2'b01:   load_val = req_sign ? {{16{half_val[15]}}, half_val}
                                      : {16'h0, half_val};
         2'b10:   load_val = cur_word;
         default: load_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && req_we && !req_err) begin
         mem[widx] <= merged_word;
      end
   end

   // The WAIT stage is always visited once, so the response appears
   // WAIT_CYCLES+1 edges after accept; loads are snapshotted at accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         rsp_valid_reg   <= 1'b0;
         err_reg         <= 1'b0;
         rdata_reg       <= '0;
         trace_valid_reg <= 1'b0;
         taddr_reg       <= '0;
         tdata_reg       <= '0;
      end else begin
         trace_valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  state_reg <= S_WAIT;
                  cnt_reg   <= WAIT_INIT;
                  err_reg   <= req_err;
                  rdata_reg <= (req_we || req_err) ? 32'h0 : load_val;
                  if (req_we && !req_err) begin
                     trace_valid_reg <= 1'b1;
                     taddr_reg       <= {req_addr[31:2], 2'b00};
                     tdata_reg       <= merged_word;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg     <= S_RESP;
                  rsp_valid_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_reg     <= S_IDLE;
                  rsp_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rdata_reg;
   assign rsp_err     = err_reg;
   assign trace_valid = trace_valid_reg;
   assign trace_addr  = taddr_reg;
   assign trace_data  = tdata_reg;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder
// Directed bench for dm_responder. Two instances share the request bus:
// u_w0 (WAIT_CYCLES=0) and u_w3 (WAIT_CYCLES=3); 'sel' routes req_valid
// and the observed outputs to one of them.
module tb_dm_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;
   bit          sel;

   logic        req_ready_0, rsp_valid_0, rsp_err_0, trace_valid_0;
   logic [31:0] rsp_rdata_0, trace_addr_0, trace_data_0;
   logic        req_ready_3, rsp_valid_3, rsp_err_3, trace_valid_3;
   logic [31:0] rsp_rdata_3, trace_addr_3, trace_data_3;

   logic        req_ready, rsp_valid, rsp_err, trace_valid;
   logic [31:0] rsp_rdata, trace_addr, trace_data;

   int total = 0;
   int bad   = 0;

   dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid && !sel), .req_ready(req_ready_0),
      .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0),
      .trace_valid(trace_valid_0), .trace_addr(trace_addr_0),
      .trace_data(trace_data_0)
   );

   dm_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid && sel), .req_ready(req_ready_3),
      .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3),
      .trace_valid(trace_valid_3), .trace_addr(trace_addr_3),
      .trace_data(trace_data_3)
   );

   always_comb begin
      req_ready   = sel ? req_ready_3   : req_ready_0;
      rsp_valid   = sel ? rsp_valid_3   : rsp_valid_0;
      rsp_err     = sel ? rsp_err_3     : rsp_err_0;
      rsp_rdata   = sel ? rsp_rdata_3   : rsp_rdata_0;
      trace_valid = sel ? trace_valid_3 : trace_valid_0;
      trace_addr  = sel ? trace_addr_3  : trace_addr_0;
      trace_data  = sel ? trace_data_3  : trace_data_0;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction. lat = edges from accept to rsp_valid rising.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int ntrace, output logic [31:0] taddr,
                         output logic [31:0] tdata, output int lat);
      int k;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      ntrace = 0; lat = -1; taddr = '0; tdata = '0; rdata = '0; err = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (trace_valid) begin
            ntrace++;
            taddr = trace_addr;
            tdata = trace_data;
         end
         if (rsp_valid) begin
            rdata = rsp_rdata;
            err   = rsp_err;
            lat   = k - 1;
            break;
         end
      end
      if (lat >= 0) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_tr;
      logic [31:0] exp_taddr;
      logic [31:0] exp_tdata;
   } vec_t;

   vec_t vecs [20];

   logic [31:0] mdl [1024];
   logic [31:0] q_rd [$];
   logic        q_err [$];

   initial begin
      logic [31:0] rd, ta, td;
      logic        er;
      int          ntr, lat;

      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_sign = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; sel = 1'b0;

      //          we    size   sgn   addr        wdata         exp_rd        err  tr taddr       tdata
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'h12345678, 32'h00000000, 1'b0, 1, 32'h010, 32'h12345678};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h12345678, 1'b0, 0, 32'h0,   32'h0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h011, 32'h00000080, 32'h00000000, 1'b0, 1, 32'h010, 32'h12348078};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h011, 32'h0,        32'hFFFFFF80, 1'b0, 0, 32'h0,   32'h0};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h011, 32'h0,        32'h00000080, 1'b0, 0, 32'h0,   32'h0};
      vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h012, 32'h0,        32'h00001234, 1'b0, 0, 32'h0,   32'h0};
      vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h12348078, 1'b0, 0, 32'h0,   32'h0};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h002, 32'h0,        32'h00000000, 1'b1, 0, 32'h0,   32'h0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h001, 32'h0000BEEF, 32'h00000000, 1'b1, 0, 32'h0,   32'h0};
      vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 32'h0,   32'h0};
      vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h1000,32'h0000DEAD, 32'h00000000, 1'b1, 0, 32'h0,   32'h0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h12348078, 1'b0, 0, 32'h0,   32'h0};
      vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h016, 32'h00008001, 32'h00000000, 1'b0, 1, 32'h014, 32'h80010000};
      vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h016, 32'h0,        32'hFFFF8001, 1'b0, 0, 32'h0,   32'h0};
      vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h016, 32'h0,        32'h00008001, 1'b0, 0, 32'h0,   32'h0};
      vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h017, 32'h0,        32'hFFFFFF80, 1'b0, 0, 32'h0,   32'h0};
      vecs[16] = '{1'b1, 2'b10, 1'b0, 32'hFFC, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1, 32'hFFC, 32'hA5A5A5A5};
      vecs[17] = '{1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0,        32'hA5A5A5A5, 1'b0, 0, 32'h0,   32'h0};
      vecs[18] = '{1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0,        32'h000000A5, 1'b0, 0, 32'h0,   32'h0};
      vecs[19] = '{1'b0, 2'b00, 1'b1, 32'hFFE, 32'h0,        32'hFFFFFFA5, 1'b0, 0, 32'h0,   32'h0};

      // Reset state, both instances.
      #2;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_rsp_err", 32'(rsp_err), 32'h0);
         chk("rst_rsp_rdata", rsp_rdata, 32'h0);
         chk("rst_trace_valid", 32'(trace_valid), 32'h0);
         chk("rst_trace_addr", trace_addr, 32'h0);
         chk("rst_trace_data", trace_data, 32'h0);
      end
      sel = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h1);

      // Table: WAIT_CYCLES=0 functional vectors.
      for (int i = 0; i < 20; i++) begin
         do_req(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
                rd, er, ntr, ta, td, lat);
         $display("vec %0d: we=%0d size=%0d addr=%h rdata=%h err=%0d trace=%0d lat=%0d",
                  i, vecs[i].we, vecs[i].size, vecs[i].addr, rd, er, ntr, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_trace_cnt", i), 32'(ntr), 32'(vecs[i].exp_tr));
         if (vecs[i].exp_tr != 0) begin
            chk($sformatf("vec%0d_trace_addr", i), ta, vecs[i].exp_taddr);
            chk($sformatf("vec%0d_trace_data", i), td, vecs[i].exp_tdata);
         end
      end

      // WAIT_CYCLES=3: store then a load whose response is back-pressured.
      @(negedge clk);
      sel = 1'b1;
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, ntr, ta, td, lat);
      $display("w3 store: addr=00000020 lat=%0d trace=%0d data=%h", lat, ntr, td);
      chk("w3_store_latency", 32'(lat), 32'd4);
      chk("w3_store_trace_cnt", 32'(ntr), 32'd1);
      chk("w3_store_trace_data", td, 32'hCAFEF00D);

      begin
         int got;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
         req_addr = 32'h20;
         @(posedge clk);
         #1 req_addr = 32'h24;          // held valid: must be ignored while busy
         got = -1;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
               got = k - 1;
               break;
            end
            chk("w3_ready_in_wait", 32'(req_ready), 32'h0);
         end
         $display("w3 load: addr=00000020 lat=%0d rdata=%h", got, rsp_rdata);
         chk("w3_load_latency", 32'(got), 32'd4);
         chk("w3_load_rdata", rsp_rdata, 32'hCAFEF00D);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("w3_hold_valid", 32'(rsp_valid), 32'h1);
            chk("w3_hold_rdata", rsp_rdata, 32'hCAFEF00D);
            chk("w3_hold_ready", 32'(req_ready), 32'h0);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0; req_valid = 1'b0;
         @(negedge clk);
         chk("w3_after_hs_valid", 32'(rsp_valid), 32'h0);
         chk("w3_after_hs_ready", 32'(req_ready), 32'h1);
      end

      // Reset during WAIT after a store: response dropped, memory cleared.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30;
      req_wdata = 32'h11112222;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rst5_trace_valid", 32'(trace_valid), 32'h1);
      chk("rst5_trace_data", trace_data, 32'h11112222);
      @(negedge clk);
      reset = 1'b0;
      #1;
      $display("reset in wait: rsp_valid=%0d trace_valid=%0d trace_data=%h",
               rsp_valid, trace_valid, trace_data);
      chk("rst5_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst5_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst5_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst5_trace_v", 32'(trace_valid), 32'h0);
      chk("rst5_trace_addr", trace_addr, 32'h0);
      chk("rst5_trace_d", trace_data, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rst5_no_rsp", 32'(rsp_valid), 32'h0);
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, ntr, ta, td, lat);
      $display("post-reset load: addr=00000030 rdata=%h lat=%0d", rd, lat);
      chk("rst5_load_rdata", rd, 32'h0);
      chk("rst5_load_latency", 32'(lat), 32'd4);
      do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, ntr, ta, td, lat);
      chk("rst5_load20_rdata", rd, 32'h0);

      // Back-to-back random traffic on WAIT_CYCLES=0 against a byte model.
      @(negedge clk);
      sel = 1'b0;
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
      begin
         int issued, got, cyc, prev, ntrace, nstores;
         issued = 0; got = 0; cyc = 0; prev = -1; ntrace = 0; nstores = 0;
         rsp_ready = 1'b1;
         while ((issued < 100 || q_rd.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (trace_valid) ntrace++;
            if (rsp_valid) begin
               if (q_rd.size() == 0) begin
                  total++; bad++;
                  $display("FAIL t6_unexpected_rsp: got rdata %h expected no response", rsp_rdata);
               end else begin
                  logic [31:0] erd;
                  logic        eer;
                  erd = q_rd.pop_front();
                  eer = q_err.pop_front();
                  $display("rand rsp %0d: rdata=%h err=%0d", got, rsp_rdata, rsp_err);
                  chk("t6_rdata", rsp_rdata, erd);
                  chk("t6_err", 32'(rsp_err), 32'(eer));
                  got++;
               end
            end
            if (req_ready) begin
               if (issued < 100) begin
                  logic        we, sg, e;
                  logic [1:0]  sz;
                  logic [31:0] a, wd, erd;
                  int          nb, w, off;
                  we = 1'($urandom_range(1));
                  sg = 1'($urandom_range(1));
                  sz = 2'($urandom_range(15) == 0 ? 3 : $urandom_range(2));
                  a  = 32'h40 + 32'($urandom_range(63));
                  if ($urandom_range(15) == 0) a = a | 32'h1000;
                  wd = $urandom;
                  nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
                  e  = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) ||
                       (sz == 2'b01 && a[0]) || (a >= 32'h1000);
                  erd = '0;
                  if (!e) begin
                     w   = int'(a[11:2]);
                     off = int'(a[1:0]);
                     if (we) begin
                        for (int b = 0; b < nb; b++) mdl[w][(off+b)*8 +: 8] = wd[b*8 +: 8];
                        nstores++;
                     end else begin
                        for (int b = 0; b < nb; b++) erd[b*8 +: 8] = mdl[w][(off+b)*8 +: 8];
                        if (sg && nb < 4 && erd[nb*8-1])
                           for (int b = nb; b < 4; b++) erd[b*8 +: 8] = 8'hFF;
                     end
                  end
                  req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
                  req_addr = a; req_wdata = wd;
                  q_rd.push_back(erd);
                  q_err.push_back(e);
                  if (prev >= 0) chk("t6_accept_interval", 32'(cyc - prev), 32'd3);
                  prev = cyc;
                  issued++;
               end else begin
                  req_valid = 1'b0;
               end
            end
         end
         req_valid = 1'b0;
         @(negedge clk);
         rsp_ready = 1'b0;
         $display("rand summary: issued=%0d responses=%0d traces=%0d stores=%0d cycles=%0d",
                  issued, got, ntrace, nstores, cyc);
         chk("t6_responses", 32'(got), 32'd100);
         chk("t6_trace_count", 32'(ntrace), 32'(nstores));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
